// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port of the LC-3b datapath between the
// instruction-fetch requester (f_*) and the data load/store requester (d_*).
// Simultaneous requests are granted round-robin. A granted access is held
// stable on mem_* until the memory acknowledges with mem_r. The winner then
// gets a one-cycle ready pulse (f_r / d_r) together with its read data.
// A watchdog forces completion of an access that is never acknowledged.
// It returns zero data in that case and sets the sticky bus_err flag.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   f_req, f_addr           fetch request (held until f_r) and address
//   f_r, f_rdata            fetch done pulse, fetch read data (held after)
//   d_req, d_we, d_addr,    data request, byte write enables
//   d_wdata                 (00 = read), address and write data
//   d_r, d_rdata            data done pulse, data read data (held after)
//   mem_en, mem_we,         memory port request: enable, byte enables,
//   mem_addr, mem_wdata     address, write data
//   mem_rdata, mem_r        memory read data, memory acknowledge
//   bus_err                 sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_r,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [1:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_r,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [1:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_r,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    // last_grant encoding: 0 = fetch was served last, 1 = data was served last
    localparam logic LG_F = 1'b0;
    localparam logic LG_D = 1'b1;

    // Value of the watchdog count in the last GNT cycle still allowed to
    // complete normally; a miss there forces completion.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_nxt;
    logic              lg_q, lg_nxt;
    logic [7:0]        wd_q, wd_nxt;

    logic              mem_en_nxt;
    logic [1:0]        mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              f_r_nxt, d_r_nxt;
    logic [DATA_W-1:0] f_rdata_nxt, d_rdata_nxt;
    logic              bus_err_nxt;

    logic              grant_f, grant_d;

    // Round-robin: a lone requester always wins; on a tie the requester
    // that was not served last wins.
    assign grant_f = f_req && (!d_req || (lg_q == LG_D));
    assign grant_d = d_req && (!f_req || (lg_q == LG_F));

    always_comb begin
        state_nxt     = state_q;
        lg_nxt        = lg_q;
        wd_nxt        = wd_q;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        f_r_nxt       = 1'b0;
        d_r_nxt       = 1'b0;
        f_rdata_nxt   = f_rdata;
        d_rdata_nxt   = d_rdata;
        bus_err_nxt   = bus_err;

        unique case (state_q)
            IDLE: begin
                if (grant_f) begin
                    state_nxt     = GNT_F;
                    lg_nxt        = LG_F;
                    wd_nxt        = 8'd0;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = 2'b00;
                    mem_addr_nxt  = f_addr;
                    mem_wdata_nxt = '0;
                end else if (grant_d) begin
                    state_nxt     = GNT_D;
                    lg_nxt        = LG_D;
                    wd_nxt        = 8'd0;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                end
            end

            // Requester inputs are not looked at here: the latched request
            // finishes even if the requester withdraws.
            GNT_F, GNT_D: begin
                if (mem_r || (wd_q == WD_LAST)) begin
                    // mem_r on the last allowed cycle still counts as a
                    // normal completion, so it is checked first.
                    state_nxt  = DONE;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 2'b00;
                    if (!mem_r) begin
                        bus_err_nxt = 1'b1;
                    end
                    if (state_q == GNT_F) begin
                        f_r_nxt     = 1'b1;
                        f_rdata_nxt = mem_r ? mem_rdata : '0;
                    end else begin
                        d_r_nxt     = 1'b1;
                        d_rdata_nxt = mem_r ? mem_rdata : '0;
                    end
                end else begin
                    wd_nxt = wd_q + 8'd1;
                end
            end

            // One dead cycle while the requester still shows its old req;
            // the r pulse drops through the default above.
            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lg_q      <= LG_D;
            wd_q      <= 8'd0;
            mem_en    <= 1'b0;
            mem_we    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_r       <= 1'b0;
            d_r       <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            lg_q      <= lg_nxt;
            wd_q      <= wd_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            f_r       <= f_r_nxt;
            d_r       <= d_r_nxt;
            f_rdata   <= f_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the LC-3b datapath. It shares the port between the instruction-fetch path and the data (LDB/LDW/STB/STW) path, holds the granted request stable until the memory answers, and returns a one-cycle ready pulse (the R the control FSM waits on) plus read data to the winner. A watchdog completes any access the memory never acknowledges and flags a bus error.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 255, max GNT cycles without mem_r before forced completion (1..255; 8-bit counter)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request, held until f_r
- f_addr  in  ADDR_W  fetch address
- f_r  out  1  fetch done, one-cycle pulse
- f_rdata  out  DATA_W  fetch read data, valid while f_r=1, held afterwards
- d_req  in  1  data request, held until d_r
- d_we  in  2  00 read, 01 low-byte write, 10 high-byte write, 11 word write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_r  out  1  data done, one-cycle pulse
- d_rdata  out  DATA_W  data read data, valid while d_r=1, held afterwards
- mem_en  out  1  memory access enable
- mem_we  out  2  byte write enables to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_r
- mem_r  in  1  memory ready/acknowledge
- bus_err  out  1  sticky: some access timed out; cleared only by reset

## Operation
- States: IDLE, GNT_F, GNT_D, DONE. All outputs registered.
- Reset (sync): state IDLE, last_grant=D (so fetch wins first tie), wd counter 0; mem_en, mem_we, mem_addr, mem_wdata, f_r, d_r, f_rdata, d_rdata, bus_err all 0.
- IDLE: only f_req -> GNT_F; only d_req -> GNT_D; both -> grant requester != last_grant (round-robin); neither -> stay. On grant: latch addr/we/wdata into mem_* outputs, mem_en=1, clear wd counter, update last_grant.
- GNT_F: mem_we=00, mem_wdata=0. GNT_D: mem_we=latched d_we. mem_* held constant for whole grant regardless of requester inputs; request withdrawal mid-grant is ignored, access completes and r still pulses.
- GNT_x with mem_r=1: capture mem_rdata into x_rdata (also on writes), pulse x_r, mem_en=0, mem_we=00, -> DONE.
- GNT_x, mem_r=0: wd counter +1; when TIMEOUT consecutive GNT cycles pass without mem_r, next edge: x_rdata=0, x_r=1, bus_err=1, mem_en=0 -> DONE. mem_r on the final allowed cycle wins (normal completion, no error).
- DONE: exactly one cycle, x_r=1, no grant (requester still shows old req this cycle); -> IDLE, x_r=0. Other requester's pending req is served from IDLE next.
- The non-granted requester's rdata and r are untouched.

## Timing
- req sampled at edge ending cycle 0 -> mem_en=1 in cycle 1.
- mem_r high in cycle k (k>=1) -> x_r=1 and rdata valid in cycle k+1 (DONE) -> IDLE in k+2.
- Minimum access: req cycle 0, mem_en cycles 1, mem_r cycle 1, r cycle 2, next grant earliest cycle 3 (mem_en cycle 4 of back-to-back). Throughput one access per 3 cycles with zero-wait memory.
- Timeout: mem_en high for exactly TIMEOUT cycles, error r in the following cycle.
- reset asserted in any cycle: next cycle all outputs at reset values, in-flight access abandoned without r pulse.

## Test plan
- Single fetch, f_addr=16'h3000, mem_r in first GNT cycle with mem_rdata=16'h1234 -> mem_en high 1 cycle, f_r pulse cycle 2, f_rdata=16'h1234, d_r stays 0.
- Byte store, d_we=10, d_addr=16'h4001, d_wdata=16'hAB00, mem_r after 3 wait cycles -> mem_we=10, addr/wdata stable 4 cycles, d_r one pulse, mem_we returns 00.
- f_req and d_req both held high from reset -> grant order F, D, F, D; each r single-cycle; no mem_en in DONE cycles.
- mem_r never asserted, TIMEOUT=4 -> mem_en high exactly 4 cycles, r pulse with rdata=0, bus_err=1 and stays 1 across later good accesses until reset.
- Reset asserted in second GNT_D cycle -> next cycle mem_en=0, no d_r pulse, bus_err=0; following d_req gets a fresh grant.
- Requester drops req mid-grant -> mem_* unchanged, access completes, r pulse issued.
